// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and sizing helper for the iterative ALU.
package alu_pkg;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_OR    = 2;
  localparam int OP_AND   = 3;
  localparam int OP_SLL   = 4;
  localparam int OP_SRL   = 5;
  localparam int OP_XOR   = 6;
  localparam int OP_SLTU  = 7;
  localparam int OP_SLT   = 8;
  localparam int OP_SRA   = 9;
  localparam int OP_MUL   = 10;
  localparam int OP_MULHU = 11;
  localparam int OP_DIVU  = 12;
  localparam int OP_REMU  = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Shift-add multiplier and restoring divider sharing one 2*WIDTH working register.
// done pulses in the cycle that performs the last step; value is that step's result.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             want_hi_or_rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] value
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               want_q, want_d;
  logic               active_q, active_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_t;
  logic [WIDTH:0]     div_diff;

  assign done = active_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    cnt_d    = cnt_q;
    work_d   = work_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    want_d   = want_q;
    active_d = active_q;

    // Multiply: upper half accumulates, lower half holds the multiplier bits still to consume.
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
             + (work_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Divide: upper half is the partial remainder, lower half shifts quotient bits in.
    div_t    = work_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_t - {1'b0, opb_q};

    if (start) begin
      cnt_d    = '0;
      work_d   = {{WIDTH{1'b0}}, a};
      opb_d    = b;
      is_div_d = is_div;
      want_d   = want_hi_or_rem;
      active_d = 1'b1;
    end else if (active_q) begin
      cnt_d = cnt_q + CW'(1);
      if (is_div_q) begin
        if (div_diff[WIDTH]) begin
          work_d = {div_t[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        end else begin
          work_d = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        work_d = {mul_sum, work_q[WIDTH-1:1]};
      end
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  assign value = want_q ? work_d[2*WIDTH-1:WIDTH] : work_d[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      work_q   <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      want_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      want_q   <= want_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle base ops plus iterative MUL/MULHU/DIVU/REMU.
// One operation in flight; result and zero flag are registered and held until taken.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             is_iter;
  logic             md_start;
  logic             md_done;
  logic             md_is_div;
  logic             md_want_hi;
  logic [WIDTH-1:0] md_value;
  logic [WIDTH-1:0] alu_res;
  logic [SH_W-1:0]  shamt;

  assign shamt      = b[SH_W-1:0];
  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign is_iter    = (opcode >= OP_W'(OP_MUL)) && (opcode <= OP_W'(OP_REMU));
  assign md_is_div  = (opcode == OP_W'(OP_DIVU)) || (opcode == OP_W'(OP_REMU));
  assign md_want_hi = (opcode == OP_W'(OP_MULHU)) || (opcode == OP_W'(OP_REMU));
  assign md_start   = accept && is_iter && !flush;

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_W'(OP_ADD):  alu_res = a + b;
      OP_W'(OP_SUB):  alu_res = a - b;
      OP_W'(OP_OR):   alu_res = a | b;
      OP_W'(OP_AND):  alu_res = a & b;
      OP_W'(OP_SLL):  alu_res = a << shamt;
      OP_W'(OP_SRL):  alu_res = a >> shamt;
      OP_W'(OP_XOR):  alu_res = a ^ b;
      OP_W'(OP_SLTU): alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_W'(OP_SLT):  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_W'(OP_SRA):  alu_res = $signed(a) >>> shamt;
      default:        alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_iter) begin
            state_d = BUSY;
          end else begin
            state_d     = DONE;
            result_d    = alu_res;
            out_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d     = DONE;
          result_d    = md_value;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          // A request taken alongside the drain goes straight on, with no bubble.
          if (accept) begin
            if (is_iter) begin
              state_d = BUSY;
            end else begin
              state_d     = DONE;
              result_d    = alu_res;
              out_valid_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
    end

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero_flag = zero_q;

  iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (md_start),
    .is_div         (md_is_div),
    .want_hi_or_rem (md_want_hi),
    .a              (a),
    .b              (b),
    .done           (md_done),
    .value          (md_value)
  );

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=32): directed cases, random ops vs an arithmetic model.
module tb_iter_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [3:0]    opcode = 4'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          zero_flag;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(W), .OP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_flag (zero_flag)
  );

  function automatic logic [W-1:0] model(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] prod;
    int unsigned sh;
    prod = 64'(x) * 64'(y);
    sh   = y % 32;
    case (op)
      0:  return x + y;
      1:  return x - y;
      2:  return x | y;
      3:  return x & y;
      4:  return x << sh;
      5:  return x >> sh;
      6:  return x ^ y;
      7:  return (x < y) ? 32'd1 : 32'd0;
      8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      9:  return W'($signed(x) >>> sh);
      10: return prod[31:0];
      11: return prod[63:32];
      12: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      13: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge with out_ready=1; returns at the negedge where out_valid is seen.
  task automatic do_op(input int op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic z, output int lat);
    opcode = 4'(op); a = x; b = y; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      vectors++; errors++;
      $display("FAIL timeout op=%0d: out_valid actual 0 required 1 within 100 cycles", op);
    end
    r = result; z = zero_flag;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, result, zero_flag} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h zero=%b required 1 0 00000000 1",
               in_ready, out_valid, result, zero_flag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_directed();
    int          ops [12] = '{0, 1, 4, 9, 8, 7, 14, 10, 11, 12, 13, 12};
    logic [W-1:0] xs [12] = '{32'hFFFF_FFFF, 32'd5, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd77, 32'h1_0000, 32'h1_0000, 32'd100, 32'd100, 32'd12345};
    logic [W-1:0] ys [12] = '{32'd1, 32'd7, 32'h21, 32'd4, 32'd1, 32'd1,
                             32'd3, 32'h1_0000, 32'h1_0000, 32'd7, 32'd7, 32'd0};
    logic [W-1:0] ex [12] = '{32'd0, 32'hFFFF_FFFE, 32'd2, 32'hF800_0000, 32'd1, 32'd0,
                             32'd0, 32'd0, 32'd1, 32'd14, 32'd2, 32'hFFFF_FFFF};
    logic [W-1:0] r;
    logic z;
    int lat;
    int exp_lat;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      do_op(ops[i], xs[i], ys[i], r, z, lat);
      exp_lat = (ops[i] >= 10 && ops[i] <= 13) ? 33 : 1;
      vectors++;
      if (r !== ex[i] || z !== (ex[i] == 0) || lat != exp_lat) begin
        errors++;
        $display("FAIL directed[%0d] op=%0d: result=%h zero=%b lat=%0d required %h %b %0d",
                 i, ops[i], r, z, lat, ex[i], (ex[i] == 0), exp_lat);
      end
      $display("directed op=%0d a=%h b=%h -> %h lat=%0d", ops[i], xs[i], ys[i], r, lat);
    end
    do_op(13, 32'd9, 32'd0, r, z, lat);
    vectors++;
    if (r !== 32'd9 || z !== 1'b0) begin
      errors++;
      $display("FAIL remu_by_zero: result=%h zero=%b required 00000009 0", r, z);
    end
    $display("directed REMU 9/0 -> %h", r);
    @(negedge clk);
  endtask

  task automatic test_busy_ready();
    int busy_ready_seen = 0;
    int lat = 1;
    opcode = 4'd10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    opcode = 4'd0; a = 32'd1; b = 32'd1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready_seen++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    vectors++;
    if (busy_ready_seen != 0 || lat != 33 || result !== 32'd15) begin
      errors++;
      $display("FAIL busy_in_ready: ready_cycles=%0d lat=%0d result=%h required 0 33 0000000f",
               busy_ready_seen, lat, result);
    end
    $display("busy MUL 3*5 -> %h lat=%0d", result, lat);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, r, e;
    logic z;
    int op, lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      if (i % 11 == 0) y = '0;
      e = model(op, x, y);
      do_op(op, x, y, r, z, lat);
      exp_lat = (op >= 10 && op <= 13) ? 33 : 1;
      vectors++;
      if (r !== e || z !== (e == 0) || lat != exp_lat) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h zero=%b lat=%0d required %h %b %0d",
                 i, op, x, y, r, z, lat, e, (e == 0), exp_lat);
      end
      $display("random op=%0d a=%h b=%h -> %h", op, x, y, r);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q[$];
    int op, v;
    logic [W-1:0] x, y, e;
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        @(posedge clk); @(negedge clk);
        e = q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || result !== e) begin
          errors++;
          $display("FAIL back_to_back[%0d]: out_valid=%b result=%h required 1 %h", i, out_valid, result, e);
        end
        $display("b2b %0d -> %h", i, result);
      end
      if (i < 16) begin
        v  = $urandom_range(0, 11);
        op = (v < 10) ? v : v + 4;
        x  = $urandom; y = $urandom;
        q.push_back(model(op, x, y));
        opcode = 4'(op); a = x; b = y; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y, e, nx, ny;
    int stable_bad = 0;
    x = $urandom; y = $urandom; e = model(6, x, y);
    out_ready = 1'b0;
    opcode = 4'd6; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    nx = $urandom; ny = $urandom;
    opcode = 4'd0;
    repeat (5) begin
      a = $urandom; b = $urandom;
      #1;
      if (out_valid !== 1'b1 || result !== e || zero_flag !== (e == 0) || in_ready !== 1'b0) stable_bad++;
      @(posedge clk); @(negedge clk);
    end
    vectors++;
    if (stable_bad != 0) begin
      errors++;
      $display("FAIL hold_stable: bad_cycles=%0d required 0 (result=%h required %h)", stable_bad, result, e);
    end
    a = nx; b = ny; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || result !== nx + ny) begin
      errors++;
      $display("FAIL no_bubble: out_valid=%b result=%h required 1 %h", out_valid, result, nx + ny);
    end
    $display("backpressure XOR %h then ADD -> %h", e, result);
    @(negedge clk);
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b1;
    opcode = 4'd12; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    repeat (40) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: valid_cycles=%0d in_ready=%b required 0 1", seen, in_ready);
    end
    $display("flush mid-DIVU checked");
    opcode = 4'd0; a = 32'd4; b = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (3) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_accept: valid_cycles=%0d required 0", seen);
    end
    $display("flush with same-cycle request checked");
  endtask

  task automatic test_async_reset();
    logic [W-1:0] r;
    logic z;
    int lat;
    do_op(0, 32'd5, 32'd6, r, z, lat);
    @(negedge clk);
    opcode = 4'd10; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (result !== 32'd11) begin
      errors++;
      $display("FAIL pre_reset_hold: result=%h required 0000000b", result);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero_flag !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b result=%h zero=%b in_ready=%b required 0 0 1 1",
               out_valid, result, zero_flag, in_ready);
    end
    $display("async reset mid-MUL checked");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, lat);
    vectors++;
    if (r !== 32'hFFFF_FFFE || lat != 33) begin
      errors++;
      $display("FAIL post_reset_mulhu: result=%h lat=%0d required fffffffe 33", r, lat);
    end
    $display("post-reset MULHU -> %h", r);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ready();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
